bitstream_uart_tx: RTL and testbench

- UART serializer that drives a fabric's Rx configuration pin from a stream of 32-bit bitstream words.
- Serves as the transmitting end of the UART config path. Used in benches and in host-side/companion SoC logic so that configuration does not depend on the SelfWriteStrobe/SelfWriteData port.
- Each accepted word is sent as 4 bytes, most-significant byte first. This matches the {b[i],b[i+1],b[i+2],b[i+3]} word packing. Each byte is framed 8N1, LSB first.

---
 rtl/bitstream_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_bitstream_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_uart_tx.sv
// bitstream_uart_tx: serializes 32-bit configuration bitstream words onto a
// UART line. Each word goes out as 4 bytes, most-significant byte first.
// Each byte is framed LSB first. Build option BITSTREAM_UART_TX_PARITY_EN
// inserts an even-parity bit (8E1); the default build sends plain 8N1.
//
// Handshake: a word is accepted on a rising CLK edge where word_valid and
// word_ready are both high. word_ready is high only in IDLE, so word_valid
// and word_data are ignored while a word is being serialized.
module bitstream_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int COUNT_W      = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        word_data,
  input  logic               word_valid,
  output logic               word_ready,
  output logic               Tx,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count,
  output logic [2:0]         dbg_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef BITSTREAM_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          shift_q, shift_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [7:0]           cur_byte;
  logic                 bit_end;

  assign cur_byte = shift_q[{byte_idx_q, 3'b000} +: 8];
  // The baud counter restarts on every bit boundary, so bit edges never drift.
  assign bit_end  = (baud_q == BAUD_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: framing sequencer and bit/byte/baud counters.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    count_d    = count_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (word_valid && ready_q) begin
          shift_d    = word_data;
          byte_idx_d = 2'd3;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef BITSTREAM_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef BITSTREAM_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_idx_q != 2'd0) begin
            // Next byte starts immediately: no idle gap inside a word.
            byte_idx_d = byte_idx_q - 2'd1;
            state_d    = S_START;
          end else begin
            count_d = count_q + COUNT_W'(1);
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so both flags flip on the same edge as the state change.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // Line driver: decoded from registered state, idle/stop high.
  always_comb begin
    Tx = 1'b1;
    unique case (state_q)
      S_START:  Tx = 1'b0;
      S_DATA:   Tx = cur_byte[bit_idx_q];
`ifdef BITSTREAM_UART_TX_PARITY_EN
      S_PARITY: Tx = ^cur_byte;
`endif
      default:  Tx = 1'b1;
    endcase
  end

  assign word_ready = ready_q;
  assign busy       = busy_q;
  assign word_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bitstream_uart_tx.sv
// Bench for bitstream_uart_tx at 16 clocks per bit with a 3-bit word counter
// so the counter wrap is reached. Bytes are pushed to a queue at handshake and
// popped by a line decoder that samples each bit at its midpoint.
module tb_bitstream_uart_tx;

  localparam int CPB     = 16;
  localparam int CNT_W   = 3;
`ifdef BITSTREAM_UART_TX_PARITY_EN
  localparam int PAR     = 1;
`else
  localparam int PAR     = 0;
`endif
  localparam int WORD_T  = 4 * (10 + PAR) * CPB;
  localparam int STOP_MID = CPB / 2 + CPB * (9 + PAR);

  logic             clk;
  logic             rst;
  logic [31:0]      word_data;
  logic             word_valid;
  logic             word_ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] word_count;
  logic [2:0]       dbg_state;

  logic [7:0]       exp_q[$];
  logic [CNT_W-1:0] exp_count;
  int               n_checks;
  int               n_pass;

  bitstream_uart_tx #(.CLKS_PER_BIT(CPB), .COUNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .Tx(tx), .busy(busy), .word_count(word_count),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  // Drives one word, returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input bit keep_valid);
    int w;
    word_data  = d;
    word_valid = 1'b1;
    w = 0;
    while (!word_ready && w < 2000) begin
      tick(1);
      w++;
    end
    check("accept_wait", 32'(w < 2000), 32'd1);
    tick(1);
    push_word(d);
    if (!keep_valid) word_valid = 1'b0;
  endtask

  // Counts edges until word_ready is seen high again.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!word_ready && cyc < 2000) begin
      tick(1);
      cyc++;
    end
  endtask

  // Line decoder: midpoint sampling, scoreboard compare on the stop bit.
  bit         mon_on;
  int         mon_cnt;
  logic [7:0] mon_byte;
  logic       mon_par;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on  = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) check("start_bit", 32'(tx), 32'd0);
      if (mon_cnt > CPB / 2 && mon_cnt <= CPB / 2 + 8 * CPB && (mon_cnt - CPB / 2) % CPB == 0)
        mon_byte[(mon_cnt - CPB / 2) / CPB - 1] = tx;
      if (mon_cnt == CPB / 2 + 9 * CPB) mon_par = tx;
      if (mon_cnt == STOP_MID) begin
        check("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(mon_byte), 32'hxxxx_xxxx);
        end else begin
          mon_exp = exp_q.pop_front();
          check("byte", 32'(mon_byte), 32'(mon_exp));
`ifdef BITSTREAM_UART_TX_PARITY_EN
          check("parity", 32'(mon_par), 32'(^mon_exp));
`endif
        end
        mon_on = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    int part;
    logic [31:0] r;
    n_checks   = 0;
    n_pass     = 0;
    exp_count  = '0;
    rst        = 1'b1;
    word_valid = 1'b0;
    word_data  = '0;
    mon_on     = 1'b0;

    // Reset values
    tick(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ready", 32'(word_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", 32'(word_ready), 32'd0);
    tick(1);
    check("ready_after_release", 32'(word_ready), 32'd1);

    // Single word: 1-cycle accept latency and exact word time
    send_word(32'hA5C30F81, 1'b0);
    check("first_start_tx", 32'(tx), 32'd0);
    check("accept_ready", 32'(word_ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    wait_ready(cyc);
    exp_count++;
    check("word_time", 32'(cyc), 32'(WORD_T));
    check("count_1", 32'(word_count), 32'(exp_count));
    check("idle_busy", 32'(busy), 32'd0);

    // Back-to-back with word_valid held high
    send_word(32'h00000000, 1'b1);
    word_data = 32'hFFFFFFFF;
    wait_ready(cyc);
    exp_count++;
    check("b2b_first_time", 32'(cyc), 32'(WORD_T));
    tick(1);
    check("b2b_accept_ready", 32'(word_ready), 32'd0);
    check("b2b_accept_busy", 32'(busy), 32'd1);
    push_word(32'hFFFFFFFF);
    word_valid = 1'b0;
    wait_ready(cyc);
    exp_count++;
    check("b2b_second_time", 32'(cyc), 32'(WORD_T));
    check("count_b2b", 32'(word_count), 32'(exp_count));

    // valid pulsed mid-frame with other data is ignored
    send_word(32'h12345678, 1'b0);
    tick(100);
    word_data  = 32'hDEADBEEF;
    word_valid = 1'b1;
    part = 101;
    for (int i = 0; i < 5; i++) begin
      check("busy_ready_low", 32'(word_ready), 32'd0);
      tick(1);
      part++;
    end
    word_valid = 1'b0;
    wait_ready(cyc);
    exp_count++;
    check("ignore_word_time", 32'(cyc + part - 1), 32'(WORD_T));
    check("count_ignore", 32'(word_count), 32'(exp_count));

    // Reset mid-frame drops the word and clears the counter
    send_word(32'hCAFEF00D, 1'b0);
    tick(299);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(word_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    exp_count = '0;
    rst = 1'b0;
    tick(CPB * 12);
    check("midrst_line_idle", 32'(tx), 32'd1);
    send_word(32'h13579BDF, 1'b0);
    wait_ready(cyc);
    exp_count++;
    check("post_rst_time", 32'(cyc), 32'(WORD_T));
    check("post_rst_count", 32'(word_count), 32'(exp_count));

    // Parity pattern word, then random words through the counter wrap
    send_word(32'h01030700, 1'b0);
    wait_ready(cyc);
    exp_count++;
    check("pattern_time", 32'(cyc), 32'(WORD_T));
    for (int i = 0; i < 7; i++) begin
      r = $urandom;
      send_word(r, 1'b0);
      tick($urandom_range(0, 3));
      wait_ready(cyc);
      exp_count++;
      check("rand_count", 32'(word_count), 32'(exp_count));
    end

    tick(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_tx_idle", 32'(tx), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
